// File: rtl/i2c_pkg.sv
// i2c_pkg: shared command encodings and FSM states for the I2C SCL engine
package i2c_pkg;
  typedef enum logic [1:0] {
    OP_START  = 2'd0,
    OP_BIT    = 2'd1,
    OP_STOP   = 2'd2,
    OP_RSTART = 2'd3
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SU,
    S_HD,
    S_LOW,
    S_HIGH,
    S_PARK
  } state_e;
endpackage

// File: rtl/i2c_phase_timer.sv
// i2c_phase_timer: phase counter that runs 0..N-1 after a load, with a length of 0 treated as 1
// Ports: load restarts the count with len; hold freezes it; expire is high on the last,
// non-held cycle of the phase.
module i2c_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             hold,
  input  logic [CNT_W-1:0] len,
  output logic             expire
);
  logic [CNT_W-1:0] cnt_q, cnt_d, lim_q, lim_d;
  assign expire = (cnt_q == lim_q) && !hold;
  always_comb begin
    lim_d = load ? ((len == '0) ? '0 : len - CNT_W'(1)) : lim_q;
    cnt_d = load ? '0 : (hold || expire) ? cnt_q : cnt_q + CNT_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end
endmodule

// File: rtl/i2c_scl_engine.sv
// i2c_scl_engine: I2C master SCL sequencer for START, BIT, STOP and repeated START
// Ports: cfg_t_low/high/su phase lengths (sampled on accept); cmd_valid/cmd_op/cmd_ready
// command handshake; scl_i sensed line; scl_oe open-drain pull-low; sda_edge, shift_pulse,
// sample_pulse, done single-cycle strobes; bit_cnt BITs since last START/RSTART.
// Build option: SCL_STRETCH_EN holds HIGH and SU timing while a slave keeps SCL low.
module i2c_scl_engine
  import i2c_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int BITS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cfg_t_low,
  input  logic [CNT_W-1:0]  cfg_t_high,
  input  logic [CNT_W-1:0]  cfg_t_su,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  output logic              cmd_ready,
  input  logic              scl_i,
  output logic              scl_oe,
  output logic              sda_edge,
  output logic              shift_pulse,
  output logic              sample_pulse,
  output logic              done,
  output logic [BITS_W-1:0] bit_cnt
);
  state_e            state_q, state_d;
  op_e               op_q, op_d, op_in;
  logic [CNT_W-1:0]  hi_q, hi_d, su_q, su_d, len;
  logic [BITS_W-1:0] bit_q, bit_d;
  logic              done_q, done_d, oe_q, oe_d, hd_q, hd_d;
  logic              acc, load, hold, expire;
  assign op_in     = op_e'(cmd_op);
  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_PARK);
  assign acc       = cmd_valid && cmd_ready;
`ifdef SCL_STRETCH_EN
  assign hold = ((state_q == S_HIGH) || (state_q == S_SU)) && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign hold       = 1'b0;
`endif
  i2c_phase_timer #(.CNT_W(CNT_W)) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .hold   (hold),
    .len    (len),
    .expire (expire)
  );
  // The accept cycle in PARK already drives SCL low, so it counts as the first cycle
  // of the new low phase; LOW then covers the remaining t_low-1 cycles.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    hi_d    = hi_q;
    su_d    = su_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    load    = 1'b0;
    len     = su_q;
    case (state_q)
      S_IDLE: if (acc && op_in == OP_START) begin
        state_d = S_HD;
        load    = 1'b1;
        len     = cfg_t_su;
        op_d    = op_in;
        su_d    = cfg_t_su;
        hi_d    = cfg_t_high;
        bit_d   = '0;
      end
      S_PARK: if (acc && op_in != OP_START) begin
        op_d    = op_in;
        su_d    = cfg_t_su;
        hi_d    = cfg_t_high;
        bit_d   = (op_in == OP_RSTART) ? '0 : bit_q;
        load    = 1'b1;
        state_d = (cfg_t_low > CNT_W'(1)) ? S_LOW : (op_in == OP_BIT) ? S_HIGH : S_SU;
        len     = (cfg_t_low > CNT_W'(1)) ? cfg_t_low - CNT_W'(1) :
                  (op_in == OP_BIT) ? cfg_t_high : cfg_t_su;
      end
      S_LOW: if (expire) begin
        load    = 1'b1;
        state_d = (op_q == OP_BIT) ? S_HIGH : S_SU;
        len     = (op_q == OP_BIT) ? hi_q : su_q;
      end
      S_HIGH: if (expire) begin
        state_d = S_PARK;
        done_d  = 1'b1;
        bit_d   = bit_q + BITS_W'(1);
      end
      S_SU: if (expire) begin
        load    = op_q != OP_STOP;
        state_d = (op_q == OP_STOP) ? S_IDLE : S_HD;
        done_d  = op_q == OP_STOP;
      end
      S_HD: if (expire) begin
        state_d = S_PARK;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    oe_d = (state_d == S_LOW) || (state_d == S_PARK);
    hd_d = (state_d == S_HD) && (state_q != S_HD);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_START;
      hi_q    <= '0;
      su_q    <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
      oe_q    <= 1'b0;
      hd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      su_q    <= su_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      oe_q    <= oe_d;
      hd_q    <= hd_d;
    end
  end
  assign scl_oe       = oe_q;
  assign done         = done_q;
  assign bit_cnt      = bit_q;
  assign sda_edge     = hd_q || (state_q == S_SU && op_q == OP_STOP && expire);
  assign shift_pulse  = acc && state_q == S_PARK && op_in == OP_BIT;
  assign sample_pulse = state_q == S_HIGH && expire;
endmodule

// File: doc/i2c_scl_engine.md
I2C_SCL_ENGINE -- requirements
Module: i2c_scl_engine

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of the phase-timing counter and timing inputs.
REQ-002 SHALL have parameter BITS_W, default 4, giving the width of the bit-position counter.
REQ-003 SHALL have port clk, input, 1, system clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cfg_t_low, input, CNT_W, SCL low-phase length in clk cycles.
REQ-006 SHALL have port cfg_t_high, input, CNT_W, SCL high-phase length in clk cycles.
REQ-007 SHALL have port cfg_t_su, input, CNT_W, START/STOP setup and hold length in clk cycles.
REQ-008 SHALL have port cmd_valid, input, 1, command request.
REQ-009 SHALL have port cmd_op, input, 2, command code: 0 START, 1 BIT, 2 STOP, 3 RSTART.
REQ-010 SHALL have port cmd_ready, output, 1, high only in IDLE or PARK; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-011 SHALL have port scl_i, input, 1, sensed SCL line level (already synchronised).
REQ-012 SHALL have port scl_oe, output, 1, open-drain drive: 1 pulls SCL low, 0 releases it.
REQ-013 SHALL have port sda_edge, output, 1, one-cycle pulse marking the point where the master changes SDA for START/STOP.
REQ-014 SHALL have port shift_pulse, output, 1, one-cycle pulse on the first cycle of a BIT low phase (change data).
REQ-015 SHALL have port sample_pulse, output, 1, one-cycle pulse on the last cycle of a BIT high phase (sample SDA).
REQ-016 SHALL have port done, output, 1, one-cycle pulse when a command completes.
REQ-017 SHALL have port bit_cnt, output, BITS_W, number of BITs completed since the last START/RSTART; wraps modulo 2^BITS_W.

Function
REQ-018 SHALL implement states IDLE (SCL released), SU (setup), HD (hold), LOW, HIGH and PARK (SCL held low between commands).
REQ-019 SHALL count each phase from 0 to N-1, lasting exactly N cycles; a configured value of 0 SHALL be treated as 1.
REQ-020 SHALL sample cfg_* values only when a command is accepted, so mid-command changes have no effect.
REQ-021 START, accepted in IDLE: HD for t_su cycles with SCL released; sda_edge on the first HD cycle; then PARK with scl_oe=1; done on the PARK entry cycle.
REQ-022 RSTART, accepted in PARK: LOW for t_low, then SU (released) for t_su, then the START sequence (HD, PARK); clears bit_cnt.
REQ-023 BIT, accepted in PARK: LOW for t_low with shift_pulse on the first cycle, then HIGH (released) for t_high with sample_pulse on the last cycle, then PARK; done and bit_cnt+1 occur on PARK entry.
REQ-024 STOP, accepted in PARK: LOW for t_low, then SU (released) for t_su with sda_edge on the last cycle, then IDLE; done on IDLE entry.
REQ-025 SHALL ignore an illegal command (BIT/STOP/RSTART in IDLE, START in PARK): accept it, change no state, emit no done.
REQ-026 A command SHALL be acceptable on the same cycle done is asserted (back-to-back, no idle gap).
REQ-027 For a BIT issued directly after START, the minimum total SCL period SHALL be t_low+t_high cycles.

Reset
REQ-028 On rst_n low, SHALL asynchronously set state IDLE, scl_oe=0, all pulses 0, bit_cnt=0, counters 0; cmd_ready=1 after release.
REQ-029 A reset mid-command SHALL abort it with no done and release SCL immediately.

Configuration
REQ-030 With SCL_STRETCH_EN defined, the HIGH and SU phase counters SHALL hold at 0 while scl_i=0 after release (slave clock stretching), and counting SHALL start on the first cycle scl_i=1.
REQ-031 Without SCL_STRETCH_EN, scl_i SHALL be ignored and phase lengths SHALL be fixed.

Structure
REQ-032 A shared package i2c_pkg SHALL hold the cmd_op encodings and the state enumeration.
REQ-033 One sub-module, i2c_phase_timer (load/count/expire with zero-as-one and hold input), SHALL be instantiated once.

Verification
REQ-034 t_low=6, t_high=4, t_su=4; START then BIT: sda_edge at HD cycle 0; done after 4 cycles; BIT shows scl_oe high 6 cycles and low 4 cycles; sample_pulse on the 4th high cycle; bit_cnt=1.
REQ-035 Nine back-to-back BITs with cmd_valid held high: no PARK gap, period exactly 10 cycles, nine done pulses, bit_cnt=9.
REQ-036 With SCL_STRETCH_EN, scl_i forced low 7 cycles into HIGH: high phase lasts 7+4 cycles and sample_pulse is delayed by 7; without the macro it is unaffected.
REQ-037 STOP from PARK: 6 low cycles, then 4 released cycles; sda_edge on the last; done; state IDLE with cmd_ready=1; a following BIT is ignored (no done).
REQ-038 cfg_t_high=0: high phase lasts 1 cycle; rst_n asserted mid-LOW: scl_oe=0 at once, no done, bit_cnt=0.
